// File: rtl/ap_arbiter_if.sv
// ap_arbiter_if: requester-side bundle between the control units and the AP selector arbiter
interface ap_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 4,
  parameter int LEN_W   = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*SEL_W-1:0] req_sel;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic [SEL_W-1:0]         ap_set;
  logic                     busy;
  modport master (output req, req_sel, req_len, input gnt, done, ap_set, busy);
  modport slave  (input req, req_sel, req_len, output gnt, done, ap_set, busy);
endinterface

// File: rtl/ap_arbiter.sv
// ap_arbiter: round-robin owner of the AP block's APSet selector for bounded-length bursts
module ap_arbiter #(
  parameter int               NUM_REQ  = 4,
  parameter int               SEL_W    = 4,
  parameter int               LEN_W    = 4,
  parameter logic [SEL_W-1:0] IDLE_SEL = '0
) (
  input  logic        clk,
  input  logic        rst,
  ap_arbiter_if.slave ap
);
  localparam int IDX_W = $clog2(NUM_REQ);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, ptr_q, win, ptr_nxt;
  logic [LEN_W-1:0]   cnt_q;
  logic [SEL_W-1:0]   sel_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               any_req, hold_on;
  assign any_req = |ap.req;
  assign hold_on = ap.req[owner_q] && cnt_q != '0;
  assign ptr_nxt = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  // winner: nearest requester at or after ptr, scanned from the far end so the closest one lands last
  always_comb begin
    win = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      logic [IDX_W-1:0] j;
      j = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (ap.req[j]) win = j;
    end
  end
  // state register
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  // next state: a burst ends on its last counted cycle or when the owner drops its request
  always_comb state_d = (state_q == IDLE) ? (any_req ? HOLD : IDLE) : (hold_on ? HOLD : IDLE);
  // outputs: everything registered except done, which is decoded from the owner's live request
  always_comb begin
    ap.gnt    = gnt_q;
    ap.ap_set = sel_q;
    ap.busy   = state_q == HOLD;
    ap.done   = (state_q == HOLD && ap.req[owner_q] && cnt_q == '0) ? gnt_q : '0;
  end
  // burst datapath: capture winner's selector/length on entry, count down, release and rotate on exit
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= IDLE_SEL;
    end else if (state_q == IDLE && any_req) begin
      owner_q <= win;
      gnt_q   <= NUM_REQ'(1) << win;
      sel_q   <= ap.req_sel[win*SEL_W +: SEL_W];
      cnt_q   <= ap.req_len[win*LEN_W +: LEN_W];
    end else if (state_q == HOLD && hold_on) begin
      cnt_q   <= cnt_q - 1'b1;
    end else if (state_q == HOLD) begin
      gnt_q   <= '0;
      sel_q   <= IDLE_SEL;
      ptr_q   <= ptr_nxt;
    end
  end
endmodule

// File: tb/tb_ap_arbiter.sv
// tb_ap_arbiter: randomized burst traffic against a transaction-level round-robin model with a scoreboard
module tb_ap_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   mptr = 0;
  typedef struct {
    int         w;
    logic [3:0] sel;
    int         cyc;
    bit         dn;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  int   n;
  bit   in_b = 1'b0;

  ap_arbiter_if #(.NUM_REQ(4), .SEL_W(4), .LEN_W(4)) bus ();
  ap_arbiter #(.NUM_REQ(4), .SEL_W(4), .LEN_W(4), .IDLE_SEL(4'd0)) dut (.clk(clk), .rst(rst), .ap(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int winner(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic run_round(input logic [3:0] r, input logic [15:0] sels, input logic [15:0] lens, input int ab);
    int w, len, ncyc;
    bus.req = r;
    bus.req_sel = sels;
    bus.req_len = lens;
    w = winner(r, mptr);
    len = int'(lens[w*4 +: 4]);
    ncyc = (ab >= 0) ? ab + 1 : len + 1;
    q.push_back('{w: w, sel: sels[w*4 +: 4], cyc: ncyc, dn: ab < 0});
    mptr = (w + 1) % 4;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      bus.req_sel = 16'($urandom);
      bus.req_len = 16'($urandom);
      bus.req = 4'($urandom) | (4'b1 << w);
      if (ab == c) bus.req[w] = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.gnt != '0) begin
        if (!in_b) begin
          if (q.size() == 0) chk("unexpected_gnt", 32'(bus.gnt), 0);
          else begin
            cur = q.pop_front();
            in_b = 1'b1;
            n = 0;
          end
        end
        if (in_b) begin
          n++;
          chk("gnt", 32'(bus.gnt), 32'(1) << cur.w);
          chk("ap_set", 32'(bus.ap_set), 32'(cur.sel));
          chk("busy", 32'(bus.busy), 1);
          chk("done", 32'(bus.done), (cur.dn && n == cur.cyc) ? 32'(1) << cur.w : 0);
          if (n > cur.cyc) chk("burst_overrun", n, cur.cyc);
        end
      end else begin
        if (in_b) begin
          chk("burst_len", n, cur.cyc);
          in_b = 1'b0;
        end
        chk("idle_ap_set", 32'(bus.ap_set), 0);
        chk("idle_done", 32'(bus.done), 0);
        chk("idle_busy", 32'(bus.busy), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int r, w, ab;
    logic [15:0] sels, lens;
    bus.req = 4'hF;
    bus.req_sel = 16'h4321;
    bus.req_len = 16'h0000;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_ap_set", 32'(bus.ap_set), 0);
      chk("rst_busy", 32'(bus.busy), 0);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (5) run_round(4'hF, 16'h4321, 16'h0000, -1);
    run_round(4'b0010, 16'h0050, 16'h0020, -1);
    run_round(4'b0100, 16'h0300, 16'h0700, 2);
    run_round(4'b1001, 16'h8001, 16'h1001, -1);
    run_round(4'b0001, 16'h0006, 16'h0004, -1);
    repeat (60) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.req = '0;
        bus.req_sel = 16'($urandom);
        @(posedge clk); #1;
      end
      r = $urandom_range(1, 15);
      sels = 16'($urandom);
      lens = 16'($urandom);
      w = winner(4'(r), mptr);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(lens[w*4 +: 4]))) : -1;
      run_round(4'(r), sels, lens, ab);
    end
    bus.req = '0;
    @(posedge clk); #1;
    mon_en = 1'b0;
    bus.req = 4'b0100;
    bus.req_sel = 16'h0700;
    bus.req_len = 16'h0500;
    @(posedge clk); #1;
    chk("mid_rst_gnt0", 32'(bus.gnt), 32'h4);
    chk("mid_rst_ap_set0", 32'(bus.ap_set), 32'h7);
    @(posedge clk); #1;
    chk("mid_rst_done1", 32'(bus.done), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_gnt", 32'(bus.gnt), 0);
    chk("mid_rst_ap_set", 32'(bus.ap_set), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    rst = 1'b0;
    mptr = 0;
    mon_en = 1'b1;
    run_round(4'b1010, 16'h0C00 | 16'h00B0, 16'h0010, -1);
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
